// File: rtl/nic_endpoint.sv
// Processor-side NIC for the four-node gold ring: one-deep input and output
// packet buffers behind a four-register processor bus, send/ready handshake to the router.
module nic_endpoint (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_polarity,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di
);

    logic [0:63] r_in_buf;
    logic        r_in_full;
    logic [0:63] r_out_buf;
    logic        r_out_full;

    logic w_rd;
    logic w_wr;
    logic w_rd_in_buf;
    logic w_wr_out_buf;
    logic w_recv;

    assign w_rd         = nicEn & ~nicWrEn;
    assign w_wr         = nicEn & nicWrEn;
    assign w_rd_in_buf  = w_rd & (addr == 2'b00);
    assign w_wr_out_buf = w_wr & (addr == 2'b10);

    assign net_ri = ~r_in_full;
    assign net_do = r_out_buf;
    // Only the VC bit is interpreted; the packet waits for the matching router phase.
    assign net_so = r_out_full & net_ro & (r_out_buf[0] == net_polarity);
    assign w_recv = net_si & ~r_in_full;

    always_comb begin
        d_out = '0;
        if (w_rd) begin
            case (addr)
                2'b00:   d_out = r_in_buf;
                2'b01:   d_out = {63'b0, r_in_full};
                2'b11:   d_out = {63'b0, r_out_full};
                default: d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else begin
            // A receive can only coincide with a read on an empty slot, so it wins.
            if (w_recv) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_rd_in_buf && r_in_full) begin
                r_in_full <= 1'b0;
            end

            // A send implies the slot was full, so a concurrent write is dropped.
            if (net_so) begin
                r_out_full <= 1'b0;
            end else if (w_wr_out_buf && !r_out_full) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nic_endpoint.sv
// Self-checking bench for nic_endpoint: directed scenarios followed by
// randomized traffic against a queue-based model of the two one-packet slots.
module tb_nic_endpoint;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;

    int unsigned checks = 0;
    int unsigned errors = 0;

    nic_endpoint dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic proc_write(input logic [1:0] a, input logic [0:63] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
        #1;
    endtask

    task automatic set_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (4) tick();
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", net_so); end
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri: got %b expected 1", net_ri); end
        reset = 1'b0;
        set_read(2'b01);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_in_status: got %h expected 0", d_out); end
        set_read(2'b11);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_out_status: got %h expected 0", d_out); end
        checks++; if (net_do !== 64'd0) begin errors++; $display("FAIL reset_net_do: got %h expected 0", net_do); end
        nicEn = 1'b0;
    endtask

    task automatic test_send();
        logic [0:63] pkt;
        pkt = 64'h0001_0001_0000_0002;
        net_ro = 1'b1; net_polarity = 1'b0;
        proc_write(2'b10, pkt);
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL send_so: got %b expected 1", net_so); end
        checks++; if (net_do !== pkt) begin errors++; $display("FAIL send_do: got %h expected %h", net_do, pkt); end
        set_read(2'b11);
        checks++; if (d_out !== 64'd1) begin errors++; $display("FAIL send_status_full: got %h expected 1", d_out); end
        tick();
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL send_status_empty: got %h expected 0", d_out); end
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL send_so_after: got %b expected 0", net_so); end
        nicEn = 1'b0; net_ro = 1'b0;
    endtask

    task automatic test_polarity();
        logic [0:63] pkt;
        pkt = 64'h8000_0000_0000_0005;
        net_ro = 1'b1; net_polarity = 1'b0;
        proc_write(2'b10, pkt);
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_mismatch_so: got %b expected 0", net_so); end
        net_polarity = 1'b1; #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL pol_match_so: got %b expected 1", net_so); end
        tick();
        set_read(2'b11);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL pol_drained: got %h expected 0", d_out); end
        nicEn = 1'b0;
        // Backpressure: matching phase but router not ready.
        net_ro = 1'b0; net_polarity = 1'b1;
        proc_write(2'b10, pkt);
        tick();
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL bp_so: got %b expected 0", net_so); end
        set_read(2'b11);
        checks++; if (d_out !== 64'd1) begin errors++; $display("FAIL bp_held: got %h expected 1", d_out); end
        net_ro = 1'b1; #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL bp_release_so: got %b expected 1", net_so); end
        tick();
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL bp_drained: got %h expected 0", d_out); end
        nicEn = 1'b0; net_ro = 1'b0; net_polarity = 1'b0;
    endtask

    task automatic test_overwrite();
        logic [0:63] first;
        first = 64'h0123_4567_89AB_CDEF;
        net_ro = 1'b0; net_polarity = 1'b0;
        proc_write(2'b10, first);
        proc_write(2'b10, 64'h0000_0000_0000_DEAD);
        checks++; if (net_do !== first) begin errors++; $display("FAIL overwrite_guard: got %h expected %h", net_do, first); end
        proc_write(2'b00, 64'h1111_1111_1111_1111);
        proc_write(2'b11, 64'h0);
        checks++; if (net_do !== first) begin errors++; $display("FAIL other_addr_write: got %h expected %h", net_do, first); end
        net_ro = 1'b1; #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL overwrite_send: got %b expected 1", net_so); end
        tick();
        net_ro = 1'b0;
        set_read(2'b11);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL overwrite_drained: got %h expected 0", d_out); end
        nicEn = 1'b0;
    endtask

    task automatic test_receive();
        logic [0:63] pkt;
        pkt = 64'h8002_0003_0000_0001;
        net_si = 1'b1; net_di = pkt;
        tick();
        net_si = 1'b0; #1;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_ri_full: got %b expected 0", net_ri); end
        set_read(2'b01);
        checks++; if (d_out !== 64'd1) begin errors++; $display("FAIL rx_status_full: got %h expected 1", d_out); end
        nicEn = 1'b0;
        net_si = 1'b1; net_di = 64'hFFFF_0000_FFFF_0000;
        tick();
        net_si = 1'b0;
        set_read(2'b00);
        checks++; if (d_out !== pkt) begin errors++; $display("FAIL rx_ignore_when_full: got %h expected %h", d_out, pkt); end
        tick();
        set_read(2'b01);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL rx_status_cleared: got %h expected 0", d_out); end
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_ri_free: got %b expected 1", net_ri); end
        set_read(2'b00);
        checks++; if (d_out !== pkt) begin errors++; $display("FAIL rx_stale_read: got %h expected %h", d_out, pkt); end
        tick();
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_stale_no_change: got %b expected 1", net_ri); end
        nicEn = 1'b0;
    endtask

    task automatic test_reset_mid();
        net_ro = 1'b0; net_polarity = 1'b0;
        net_si = 1'b1; net_di = 64'h0000_0000_0000_0077;
        proc_write(2'b10, 64'h0000_0000_0000_0042);
        net_si = 1'b0; #1;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL mid_pre_ri: got %b expected 0", net_ri); end
        #2 reset = 1'b1; #1;
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL mid_async_ri: got %b expected 1", net_ri); end
        tick();
        reset = 1'b0;
        net_ro = 1'b1; #1;
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mid_so: got %b expected 0", net_so); end
        set_read(2'b01);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL mid_in_status: got %h expected 0", d_out); end
        set_read(2'b11);
        checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL mid_out_status: got %h expected 0", d_out); end
        idle_inputs(); #1;
    endtask

    // Model: each direction is a FIFO of capacity one; the last packet
    // written into each slot stays visible after it drains.
    task automatic test_random();
        logic [0:63] in_q[$];
        logic [0:63] out_q[$];
        logic [0:63] in_last;
        logic [0:63] out_last;
        logic [0:63] exp_dout;
        logic        exp_so;
        logic        exp_ri;
        in_last = '0; out_last = '0;
        for (int unsigned cyc = 0; cyc < 600; cyc++) begin
            nicEn        = ($urandom_range(0, 3) != 0);
            nicWrEn      = $urandom_range(0, 1);
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_ro       = ($urandom_range(0, 3) != 0);
            net_polarity = $urandom_range(0, 1);
            net_si       = $urandom_range(0, 1);
            net_di       = {$urandom, $urandom};
            #1;
            exp_ri = (in_q.size() == 0);
            exp_so = (out_q.size() == 1) && net_ro && (out_last[0] == net_polarity);
            exp_dout = '0;
            if (nicEn && !nicWrEn) begin
                if (addr == 2'd0) exp_dout = in_last;
                else if (addr == 2'd1) exp_dout = 64'(in_q.size());
                else if (addr == 2'd3) exp_dout = 64'(out_q.size());
            end
            checks++; if (d_out !== exp_dout) begin errors++; $display("FAIL rand_d_out cyc %0d: got %h expected %h", cyc, d_out, exp_dout); end
            checks++; if (net_so !== exp_so) begin errors++; $display("FAIL rand_net_so cyc %0d: got %b expected %b", cyc, net_so, exp_so); end
            checks++; if (net_ri !== exp_ri) begin errors++; $display("FAIL rand_net_ri cyc %0d: got %b expected %b", cyc, net_ri, exp_ri); end
            checks++; if (net_do !== out_last) begin errors++; $display("FAIL rand_net_do cyc %0d: got %h expected %h", cyc, net_do, out_last); end
            if (net_si && in_q.size() == 0) begin
                in_q.push_back(net_di);
                in_last = net_di;
            end else if (nicEn && !nicWrEn && addr == 2'd0 && in_q.size() == 1) begin
                void'(in_q.pop_front());
            end
            if (exp_so) begin
                void'(out_q.pop_front());
            end else if (nicEn && nicWrEn && addr == 2'd2 && out_q.size() == 0) begin
                out_q.push_back(d_in);
                out_last = d_in;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_send();
        test_polarity();
        test_overwrite();
        test_receive();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
